// File: rtl/pll_lock_supervisor.sv
// ECP5 PLL lock supervisor: pulses PLL reset, waits for a qualified lock, then releases the system reset.
// Optional lock-loss logging is enabled by defining PLL_SUP_LOSS_LOG_EN.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES  = 2,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [3:0]             retry_inc;

    // pll_locked is asynchronous to clk; only the last synchronizer stage may feed decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        retry_inc = retry_cnt;
        if (retry_cnt != 4'hF) begin
            retry_inc = retry_cnt + 4'd1;
        end
    end

    // NOTE: every output is a register updated on the same edge as the state, so no glitches reach the PLL or system reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            case (state)
                S_PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen on the timeout edge takes priority over the retry.
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_cnt <= retry_inc;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        if (MAX_RETRIES != 0 && retry_inc == RETRY_LIMIT) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_PLL_RESET;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                        retry_cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_PLL_RESET;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                    end
                end
                S_FAULT: begin
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state     <= S_PLL_RESET;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SUP_LOSS_LOG_EN
    logic loss_event;

    assign loss_event = (state == S_RUN) && !locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= 8'd0;
        end else if (loss_event && loss_cnt != 8'hFF) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase-level reference model predicts the outputs
// after every edge, a monitor compares them; directed scenarios are followed by random lock activity.
module tb_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int RP   = 4;
    localparam int LS   = 8;
    localparam int TO   = 32;
    localparam int MR   = 2;
`ifdef PLL_SUP_LOSS_LOG_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES (SYNC),
        .RST_PULSE   (RP),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(TO),
        .MAX_RETRIES (MR),
        .CNT_W       (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the supervisor's life as a sequence of phases, with outputs derived from the phase.
    typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} mphase_t;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst_n;
        logic       ready;
        logic       fault;
        logic [3:0] retry;
        logic [7:0] loss;
    } exp_t;

    mphase_t m_phase;
    int      m_t;
    int      m_retries;
    int      m_losses;
    bit      sync_m[$];
    exp_t    exp_q[$];
    event    pushed_ev;

    task automatic model_reset();
        m_phase   = M_RESET;
        m_t       = 0;
        m_retries = 0;
        m_losses  = 0;
        sync_m.delete();
        for (int i = 0; i < SYNC; i++) sync_m.push_back(1'b0);
    endtask

    task automatic enter(input mphase_t p);
        m_phase = p;
        m_t     = 0;
    endtask

    task automatic model_step();
        bit ls;
        ls = sync_m[SYNC-1];
        void'(sync_m.pop_back());
        sync_m.push_front(pll_locked);
        case (m_phase)
            M_RESET: if (m_t == RP - 1) enter(M_WAIT); else m_t++;
            M_WAIT: begin
                if (ls) enter(M_STABLE);
                else if (m_t == TO - 1) begin
                    m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                    if (MR != 0 && m_retries == MR) enter(M_FAULT);
                    else enter(M_RESET);
                end else m_t++;
            end
            M_STABLE: begin
                if (!ls) enter(M_WAIT);
                else if (m_t == LS - 1) begin
                    enter(M_RUN);
                    m_retries = 0;
                end else m_t++;
            end
            M_RUN: begin
                if (!ls) begin
                    enter(M_RESET);
                    if (LOSS_ON != 0 && m_losses < 255) m_losses++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.pll_rst   = (m_phase == M_RESET) || (m_phase == M_FAULT);
        e.sys_rst_n = (m_phase == M_RUN);
        e.ready     = (m_phase == M_RUN);
        e.fault     = (m_phase == M_FAULT);
        e.retry     = 4'(m_retries);
        e.loss      = 8'(m_losses);
        return e;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
            exp_q.push_back(expected());
            -> pushed_ev;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(pushed_ev);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pll_rst",   pll_rst,   e.pll_rst);
                check("sb_sys_rst_n", sys_rst_n, e.sys_rst_n);
                check("sb_ready",     ready,     e.ready);
                check("sb_fault",     fault,     e.fault);
                check("sb_retry_cnt", retry_cnt, e.retry);
                check("sb_loss_cnt",  loss_cnt,  e.loss);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n, input logic v);
        repeat (n) begin
            @(negedge clk);
            pll_locked = v;
        end
    endtask

    // Returns on the negedge where the model shows phase p (and count t, unless t<0).
    task automatic wait_model(input mphase_t p, input int t, input int limit, input string name);
        bit found = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (m_phase == p && (t < 0 || m_t == t)) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_ready(input int limit, input string name);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        check(name, 32'(ready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        bit  saw_rst;
        logic v;

        repeat (3) @(negedge clk);
        check("reset_pll_rst",   32'(pll_rst),   32'd1);
        check("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("reset_fault",     32'(fault),     32'd0);
        rst_n = 1'b1;

        // Clean lock: lock rises two cycles after pll_rst falls.
        wait_model(M_WAIT, 0, 20, "clean_reach_wait");
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!sys_rst_n && n < 40);
        check("clean_release_edge", 32'(n), 32'd11);
        check("clean_ready",        32'(ready), 32'd1);
        check("clean_retry_cnt",    32'(retry_cnt), 32'd0);

        // One-cycle lock loss in RUN.
        idle(3, 1'b1);
        @(negedge clk);
        pll_locked = 1'b0;
        @(posedge clk);
        #1 n = 1;
        @(negedge clk);
        pll_locked = 1'b1;
        while (sys_rst_n && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("loss_drop_edge", 32'(n), 32'd3);
        check("loss_ready_low", 32'(ready), 32'd0);
        wait_ready(60, "loss_relock_ready");
        check("loss_cnt_after_loss", 32'(loss_cnt), 32'(LOSS_ON));

        // Glitch during STABLE: no new PLL reset, no retry change.
        @(negedge clk);
        pll_locked = 1'b0;
        wait_model(M_WAIT, -1, 30, "glitch_reach_wait");
        pll_locked = 1'b1;
        wait_model(M_STABLE, 4, 20, "glitch_stable5");
        saw_rst = 1'b0;
        pll_locked = 1'b0;
        idle(2, 1'b0);
        @(negedge clk);
        pll_locked = 1'b1;
        for (int k = 0; k < 40 && ready !== 1'b1; k++) begin
            @(negedge clk);
            saw_rst |= pll_rst;
        end
        check("glitch_no_pll_rst", 32'(saw_rst), 32'd0);
        check("glitch_ready",      32'(ready), 32'd1);
        check("glitch_retry_cnt",  32'(retry_cnt), 32'd0);

        // Asynchronous reset in the middle of WAIT_LOCK.
        pll_locked = 1'b0;
        pulse_reset();
        wait_model(M_WAIT, 20, 60, "async_reach_cnt20");
        #1 rst_n = 1'b0;
        #1;
        check("async_pll_rst",   32'(pll_rst),   32'd1);
        check("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (pll_rst && n < 20);
        check("async_restart_pulse", 32'(n), 32'd4);

        // No lock at all: two timeouts, then FAULT, which ignores the lock input.
        wait_model(M_FAULT, -1, 200, "nolock_reach_fault");
        check("nolock_fault",     32'(fault),     32'd1);
        check("nolock_retry_cnt", 32'(retry_cnt), 32'd2);
        check("nolock_pll_rst",   32'(pll_rst),   32'd1);
        check("nolock_sys_rst_n", 32'(sys_rst_n), 32'd0);
        for (int k = 0; k < 30; k++) idle(1, logic'($urandom_range(0, 1)));
        check("fault_sticky", 32'(fault), 32'd1);

        // First attempt times out, second one locks.
        pll_locked = 1'b0;
        pulse_reset();
        wait_model(M_WAIT, 0, 20, "retry_first_wait");
        wait_model(M_WAIT, 0, 60, "retry_second_wait");
        check("retry_after_timeout", 32'(retry_cnt), 32'd1);
        pll_locked = 1'b1;
        wait_ready(40, "retry_ready");
        check("retry_cleared",     32'(retry_cnt), 32'd0);
        check("retry_fault_clear", 32'(fault),     32'd0);

        // Random lock activity with occasional resets.
        for (int it = 0; it < 150; it++) begin
            if (m_phase == M_FAULT || $urandom_range(0, 19) == 0) begin
                pulse_reset();
            end else begin
                v = logic'($urandom_range(0, 1));
                idle(v ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 40)), v);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
